// File: rtl/rom_upload_sequencer_if.sv
// SDRAM port-1 write channel: level request, one-cycle ack, word address/data/byte enables.
interface rom_upload_sequencer_if;
  logic        sd_req;
  logic        sd_ack;
  logic [21:0] sd_addr;
  logic [1:0]  sd_ds;
  logic [15:0] sd_din;

  modport master (output sd_req, sd_addr, sd_ds, sd_din, input sd_ack);
  modport slave  (input sd_req, sd_addr, sd_ds, sd_din, output sd_ack);
endinterface

// File: rtl/rom_upload_sequencer.sv
// ROM download sequencer: pairs ioctl bytes into SDRAM word writes through a small FIFO
// and owns the load/drain/hold/run phase that gates ROM reads and the core reset.
module rom_upload_sequencer #(
  parameter logic [7:0]  ROM_INDEX  = 8'h00,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned RESET_HOLD = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  rom_upload_sequencer_if.master sd,
  output logic        rom_oe,
  output logic        rom_loaded,
  output logic        core_reset,
  output logic        overflow
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned HOLD_W = $clog2(RESET_HOLD + 1);

  typedef struct packed {
    logic [21:0] addr;
    logic [1:0]  ds;
    logic [15:0] din;
  } wr_word_t;

  typedef enum logic [1:0] {WR_IDLE, WR_REQ, WR_GAP} wr_state_t;
  typedef enum logic [1:0] {PH_LOAD, PH_DRAIN, PH_HOLD, PH_RUN} phase_t;

  logic dl_match, dl_match_q, dl_start, dl_end, accept;

  logic        pend_valid_q, pend_valid_d;
  logic [23:0] pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        skid_valid_q, skid_valid_d;
  wr_word_t    skid_q, skid_d;
  wr_word_t    lone_lo, lone_hi, new0, new1, push_word;
  logic [1:0]  new_cnt;
  logic        push, push_ok, pop, fifo_full, fifo_empty;

  wr_word_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     cnt_q;

  wr_state_t   wr_state_q, wr_state_d;
  logic        req_q, req_d;
  wr_word_t    word_q, word_d;
  phase_t      phase_q, phase_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

  assign dl_match   = ioctl_download && (ioctl_index == ROM_INDEX);
  assign dl_start   = dl_match && !dl_match_q;
  assign dl_end     = !dl_match && dl_match_q;
  assign accept     = dl_match && ioctl_wr;
  assign lone_lo    = {pend_addr_q[21:0], 2'b01, pend_data_q, pend_data_q};
  assign lone_hi    = {ioctl_addr[22:1], 2'b10, ioctl_dout, ioctl_dout};
  assign fifo_full  = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (cnt_q == CNT_W'(0));
  assign pop        = (wr_state_q == WR_REQ) && sd.sd_ack;
  assign push_ok    = push && (!fifo_full || pop);

  // Byte pairing: up to two words per accepted byte, in address order.
  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_addr_d  = pend_addr_q;
    pend_data_d  = pend_data_q;
    new_cnt      = 2'd0;
    new0         = '0;
    new1         = '0;
    if (accept) begin
      if (!ioctl_addr[0]) begin
        if (pend_valid_q) begin
          new0    = lone_lo;
          new_cnt = 2'd1;
        end
        pend_valid_d = 1'b1;
        pend_addr_d  = ioctl_addr[24:1];
        pend_data_d  = ioctl_dout;
      end else if (pend_valid_q && (pend_addr_q == ioctl_addr[24:1])) begin
        new0         = {ioctl_addr[22:1], 2'b11, ioctl_dout, pend_data_q};
        new_cnt      = 2'd1;
        pend_valid_d = 1'b0;
      end else begin
        if (pend_valid_q) begin
          new0    = lone_lo;
          new1    = lone_hi;
          new_cnt = 2'd2;
        end else begin
          new0    = lone_hi;
          new_cnt = 2'd1;
        end
        pend_valid_d = 1'b0;
      end
    end else if (dl_end && pend_valid_q) begin
      new0         = lone_lo;
      new_cnt      = 2'd1;
      pend_valid_d = 1'b0;
    end
  end

  // One FIFO push per cycle; the second word of a pair waits in the skid register.
  always_comb begin
    push         = 1'b0;
    push_word    = new0;
    skid_valid_d = 1'b0;
    skid_d       = skid_q;
    if (skid_valid_q) begin
      push      = 1'b1;
      push_word = skid_q;
      if (new_cnt != 2'd0) begin
        skid_valid_d = 1'b1;
        skid_d       = new0;
      end
    end else begin
      push = (new_cnt != 2'd0);
      if (new_cnt == 2'd2) begin
        skid_valid_d = 1'b1;
        skid_d       = new1;
      end
    end
  end

  // SDRAM write handshake: IDLE -> REQ (until ack) -> GAP -> IDLE.
  always_comb begin
    wr_state_d = wr_state_q;
    req_d      = req_q;
    word_d     = word_q;
    case (wr_state_q)
      WR_IDLE: if (!fifo_empty) begin
        word_d     = mem[rd_ptr_q];
        req_d      = 1'b1;
        wr_state_d = WR_REQ;
      end
      WR_REQ: if (sd.sd_ack) begin
        req_d      = 1'b0;
        wr_state_d = WR_GAP;
      end
      WR_GAP:  wr_state_d = WR_IDLE;
      default: wr_state_d = WR_IDLE;
    endcase
  end

  // Load phase; a matching download start always restarts LOAD.
  always_comb begin
    phase_d    = phase_q;
    hold_cnt_d = '0;
    if (dl_start) begin
      phase_d = PH_LOAD;
    end else begin
      case (phase_q)
        PH_LOAD:  if (dl_end) phase_d = PH_DRAIN;
        PH_DRAIN: if (fifo_empty && !pend_valid_q && !skid_valid_q && (wr_state_q == WR_IDLE))
                    phase_d = PH_HOLD;
        PH_HOLD:  if (hold_cnt_q == HOLD_W'(RESET_HOLD - 1)) phase_d = PH_RUN;
                  else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        PH_RUN:   phase_d = PH_RUN;
        default:  phase_d = PH_LOAD;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push_ok) mem[wr_ptr_q] <= push_word;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dl_match_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      overflow     <= 1'b0;
      wr_state_q   <= WR_IDLE;
      req_q        <= 1'b0;
      word_q       <= '0;
      phase_q      <= PH_LOAD;
      hold_cnt_q   <= '0;
      rom_oe       <= 1'b0;
      rom_loaded   <= 1'b0;
      core_reset   <= 1'b1;
    end else begin
      dl_match_q   <= dl_match;
      pend_valid_q <= pend_valid_d;
      pend_addr_q  <= pend_addr_d;
      pend_data_q  <= pend_data_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
      if (push && !push_ok) overflow <= 1'b1;
      else if (dl_start)    overflow <= 1'b0;
      wr_state_q   <= wr_state_d;
      req_q        <= req_d;
      word_q       <= word_d;
      phase_q      <= phase_d;
      hold_cnt_q   <= hold_cnt_d;
      rom_oe       <= (phase_d == PH_HOLD) || (phase_d == PH_RUN);
      rom_loaded   <= (phase_d == PH_HOLD) || (phase_d == PH_RUN);
      core_reset   <= (phase_d != PH_RUN);
    end
  end

  assign sd.sd_req  = req_q;
  assign sd.sd_addr = word_q.addr;
  assign sd.sd_ds   = word_q.ds;
  assign sd.sd_din  = word_q.din;

endmodule

// File: tb/tb_rom_upload_sequencer.sv
// Scoreboarded bench for rom_upload_sequencer: directed downloads, an SDRAM responder
// that checks each write against the expected queue, and phase/flag checks.
module tb_rom_upload_sequencer;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = 8'h00;
  logic        rom_oe, rom_loaded, core_reset, overflow;

  rom_upload_sequencer_if sd_bus();

  rom_upload_sequencer #(.ROM_INDEX(8'h00), .FIFO_DEPTH(4), .RESET_HOLD(16)) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_index    (ioctl_index),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .sd             (sd_bus),
    .rom_oe         (rom_oe),
    .rom_loaded     (rom_loaded),
    .core_reset     (core_reset),
    .overflow       (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];
  int ack_delay = 2;
  bit spurious_gap = 1'b0;
  bit hold_ack = 1'b0;
  int idle_pokes = 0;
  int req_count = 0;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [21:0] addr, input logic [1:0] ds, input logic [15:0] din);
    exp_q.push_back({addr, ds, din});
  endtask

  // SDRAM responder and write monitor: compares each request, then acks after ack_delay.
  initial begin : responder
    sd_bus.sd_ack = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_bus.sd_req === 1'b1 && !reset) begin
        req_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got %h expected none",
                   {sd_bus.sd_addr, sd_bus.sd_ds, sd_bus.sd_din});
        end else begin
          check("sd_write", {sd_bus.sd_addr, sd_bus.sd_ds, sd_bus.sd_din}, exp_q.pop_front());
        end
        for (int i = 0; i < ack_delay; i++) @(negedge clk_sys);
        while (hold_ack) @(negedge clk_sys);
        sd_bus.sd_ack = 1'b1;
        @(negedge clk_sys);
        if (spurious_gap) @(negedge clk_sys);
        sd_bus.sd_ack = 1'b0;
      end else if (idle_pokes > 0) begin
        sd_bus.sd_ack = 1'b1;
        @(negedge clk_sys);
        sd_bus.sd_ack = 1'b0;
        idle_pokes--;
      end
    end
  end

  task automatic start_dl(input logic [7:0] idx);
    @(posedge clk_sys); #1;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
  endtask

  task automatic end_dl();
    @(posedge clk_sys); #1;
    ioctl_download = 1'b0;
  endtask

  task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input int gap);
    @(posedge clk_sys); #1;
    ioctl_addr = addr;
    ioctl_dout = data;
    ioctl_wr   = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b0;
    repeat (gap) @(posedge clk_sys);
  endtask

  task automatic wait_run(input string name, input int budget);
    int n = 0;
    while (!(core_reset === 1'b0 && exp_q.size() == 0 && sd_bus.sd_req === 1'b0) && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check({name, "_timeout"}, 40'(n >= budget), 40'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int n;
    int rc;
    #1 reset = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_sd_req",     40'(sd_bus.sd_req),  40'd0);
    check("rst_sd_addr",    40'(sd_bus.sd_addr), 40'd0);
    check("rst_sd_ds",      40'(sd_bus.sd_ds),   40'd0);
    check("rst_sd_din",     40'(sd_bus.sd_din),  40'd0);
    check("rst_rom_oe",     40'(rom_oe),         40'd0);
    check("rst_rom_loaded", 40'(rom_loaded),     40'd0);
    check("rst_core_reset", 40'(core_reset),     40'd1);
    check("rst_overflow",   40'(overflow),       40'd0);
    @(negedge clk_sys) reset = 1'b0;

    // Single paired word, then hold-off count
    push_exp(22'd0, 2'b11, 16'h2211);
    start_dl(8'h00);
    send_byte(25'd0, 8'h11, 0);
    send_byte(25'd1, 8'h22, 0);
    end_dl();
    n = 0;
    while (rom_loaded !== 1'b1 && n < 300) begin
      @(negedge clk_sys);
      n++;
    end
    check("t1_loaded_timeout", 40'(n >= 300), 40'd0);
    check("t1_rom_oe_hold",     40'(rom_oe),     40'd1);
    check("t1_core_reset_hold", 40'(core_reset), 40'd1);
    n = 0;
    while (core_reset !== 1'b0 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("t1_hold_cycles", 40'(n), 40'd16);
    check("t1_writes_left", 40'(exp_q.size()), 40'd0);

    // Odd length: trailing low byte flushed at download end
    push_exp(22'd0, 2'b11, 16'hBBAA);
    push_exp(22'd1, 2'b01, 16'hCCCC);
    start_dl(8'h00);
    repeat (2) @(negedge clk_sys);
    check("t2_load_rom_oe",     40'(rom_oe),     40'd0);
    check("t2_load_core_reset", 40'(core_reset), 40'd1);
    check("t2_load_rom_loaded", 40'(rom_loaded), 40'd0);
    send_byte(25'd0, 8'hAA, 0);
    send_byte(25'd1, 8'hBB, 0);
    send_byte(25'd2, 8'hCC, 0);
    end_dl();
    wait_run("t2", 500);
    check("t2_rom_loaded", 40'(rom_loaded), 40'd1);

    // Slow acks: four words fit, the last two are dropped
    ack_delay = 40;
    push_exp(22'd0, 2'b11, 16'h4140);
    push_exp(22'd1, 2'b11, 16'h4342);
    push_exp(22'd2, 2'b11, 16'h4544);
    push_exp(22'd3, 2'b11, 16'h4746);
    start_dl(8'h00);
    for (int k = 0; k < 12; k++) send_byte(25'(k), 8'(8'h40 + k), 0);
    end_dl();
    @(negedge clk_sys);
    check("t3_overflow_set", 40'(overflow), 40'd1);
    wait_run("t3", 2000);
    ack_delay = 2;
    check("t3_overflow_sticky", 40'(overflow), 40'd1);

    // Non-matching index is ignored entirely
    rc = req_count;
    start_dl(8'h01);
    for (int k = 0; k < 4; k++) send_byte(25'(k), 8'(8'h55 + k), 0);
    end_dl();
    repeat (20) @(negedge clk_sys);
    check("t4_no_req",      40'(req_count),  40'(rc));
    check("t4_rom_loaded",  40'(rom_loaded), 40'd1);
    check("t4_core_reset",  40'(core_reset), 40'd0);
    check("t4_overflow",    40'(overflow),   40'd1);

    // Spurious acks in IDLE and GAP; lone, flushed and skidded words
    idle_pokes = 3;
    repeat (10) @(negedge clk_sys);
    spurious_gap = 1'b1;
    push_exp(22'd2, 2'b11, 16'h6261);
    push_exp(22'd3, 2'b11, 16'h6463);
    push_exp(22'd4, 2'b10, 16'h7777);
    push_exp(22'd5, 2'b01, 16'h8888);
    push_exp(22'd6, 2'b10, 16'h9999);
    push_exp(22'd7, 2'b01, 16'hA0A0);
    push_exp(22'd8, 2'b01, 16'hA2A2);
    start_dl(8'h00);
    repeat (2) @(negedge clk_sys);
    check("t6_overflow_cleared", 40'(overflow), 40'd0);
    send_byte(25'd4,  8'h61, 2);
    send_byte(25'd5,  8'h62, 2);
    send_byte(25'd6,  8'h63, 2);
    send_byte(25'd7,  8'h64, 2);
    send_byte(25'd9,  8'h77, 2);
    send_byte(25'd10, 8'h88, 2);
    send_byte(25'd13, 8'h99, 2);
    send_byte(25'd14, 8'hA0, 2);
    send_byte(25'd16, 8'hA2, 2);
    end_dl();
    wait_run("t6", 1000);
    spurious_gap = 1'b0;
    check("t6_no_overflow", 40'(overflow), 40'd0);

    // Reset while a request is outstanding
    hold_ack = 1'b1;
    push_exp(22'd0, 2'b11, 16'hD2D1);
    start_dl(8'h00);
    send_byte(25'd0, 8'hD1, 0);
    send_byte(25'd1, 8'hD2, 0);
    n = 0;
    while (sd_bus.sd_req !== 1'b1 && n < 50) begin
      @(negedge clk_sys);
      n++;
    end
    check("t5_req_timeout", 40'(n >= 50), 40'd0);
    @(negedge clk_sys); #1;
    reset = 1'b1;
    ioctl_download = 1'b0;
    #1;
    check("t5_async_sd_req",     40'(sd_bus.sd_req), 40'd0);
    check("t5_async_core_reset", 40'(core_reset),    40'd1);
    check("t5_async_rom_loaded", 40'(rom_loaded),    40'd0);
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys) reset = 1'b0;
    hold_ack = 1'b0;
    rc = req_count;
    repeat (30) @(negedge clk_sys);
    check("t5_fifo_empty_no_req", 40'(req_count),  40'(rc));
    check("t5_core_reset_held",   40'(core_reset), 40'd1);
    check("final_writes_left",    40'(exp_q.size()), 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
